// File: rtl/copperv_lsu_if.sv
// Bus bundle between the core MEM stage, the LSU and the copperv data bus.
// The LSU takes the master view; the core/bus side takes the slave view.
interface copperv_lsu_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 5
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [FUNCT_WIDTH-1:0]  req_funct;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_error;
    logic                    dr_addr_valid;
    logic                    dr_addr_ready;
    logic [ADDR_WIDTH-1:0]   dr_addr;
    logic                    dr_data_valid;
    logic                    dr_data_ready;
    logic [DATA_WIDTH-1:0]   dr_data;
    logic                    dw_valid;
    logic                    dw_ready;
    logic [ADDR_WIDTH-1:0]   dw_addr;
    logic [DATA_WIDTH-1:0]   dw_data;
    logic [DATA_WIDTH/8-1:0] dw_strobe;
    logic                    dw_resp_valid;
    logic                    dw_resp_ready;
    logic                    dw_resp;

    modport master (
        input  req_valid, req_write, req_funct, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output dr_addr_valid, dr_addr, dr_data_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        output dw_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        input  dw_ready, dw_resp_valid, dw_resp
    );

    modport slave (
        output req_valid, req_write, req_funct, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  dr_addr_valid, dr_addr, dr_data_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        input  dw_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        output dw_ready, dw_resp_valid, dw_resp
    );
endinterface

// File: rtl/copperv_lsu.sv
// Load/store unit: one request at a time, lane steering, extension,
// misalignment, write-fail and bus-timeout error reporting.
module copperv_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int FUNCT_WIDTH    = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic           clk,
    input logic           rst,
    copperv_lsu_if.master bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WREQ  = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [FUNCT_WIDTH-1:0] F_BYTE   = FUNCT_WIDTH'(9);
    localparam logic [FUNCT_WIDTH-1:0] F_HWORD  = FUNCT_WIDTH'(10);
    localparam logic [FUNCT_WIDTH-1:0] F_WORD   = FUNCT_WIDTH'(11);
    localparam logic [FUNCT_WIDTH-1:0] F_BYTEU  = FUNCT_WIDTH'(12);
    localparam logic [FUNCT_WIDTH-1:0] F_HWORDU = FUNCT_WIDTH'(13);

    logic [2:0]             state;
    logic [FUNCT_WIDTH-1:0] funct_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;
    logic [CW-1:0]          cnt;

    logic [1:0]             req_size;
    logic [1:0]             cur_size;
    logic                   req_bad;
    logic [OW-1:0]          off;
    logic [ADDR_WIDTH-1:0]  aligned;
    logic [DATA_WIDTH-1:0]  rshift;
    logic [DATA_WIDTH-1:0]  ld_ext;
    logic [NB-1:0]          smask;
    logic                   to_hit;

    // 0 = unsupported, 1 = byte, 2 = halfword, 3 = word
    function automatic logic [1:0] size_of(
        input logic [FUNCT_WIDTH-1:0] f
    );
        unique case (f)
            F_BYTE, F_BYTEU:   size_of = 2'd1;
            F_HWORD, F_HWORDU: size_of = 2'd2;
            F_WORD:            size_of = 2'd3;
            default:           size_of = 2'd0;
        endcase
    endfunction

    assign req_size = size_of(bus.req_funct);
    assign cur_size = size_of(funct_q);
    assign req_bad  = (req_size == 2'd0)
                   || (req_size == 2'd2 && bus.req_addr[0])
                   || (req_size == 2'd3 && bus.req_addr[1:0] != 2'b00);

    assign off     = addr_q[OW-1:0];
    assign aligned = {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    assign rshift  = bus.dr_data >> {off, 3'b000};

    always_comb begin
        ld_ext = rshift;
        unique case (1'b1)
            funct_q == F_BYTE:   ld_ext = DATA_WIDTH'($signed(rshift[7:0]));
            funct_q == F_BYTEU:  ld_ext = DATA_WIDTH'(rshift[7:0]);
            funct_q == F_HWORD:  ld_ext = DATA_WIDTH'($signed(rshift[15:0]));
            funct_q == F_HWORDU: ld_ext = DATA_WIDTH'(rshift[15:0]);
            funct_q == F_WORD:   ld_ext = DATA_WIDTH'($signed(rshift[31:0]));
            default: ;
        endcase
    end

    always_comb begin
        smask = '0;
        unique case (cur_size)
            2'd1:    smask = NB'(4'h1);
            2'd2:    smask = NB'(4'h3);
            2'd3:    smask = NB'(4'hF);
            default: smask = '0;
        endcase
    end

    assign to_hit = (TIMEOUT_CYCLES != 0)
                 && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            funct_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CW'(1);
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        funct_q <= bus.req_funct;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_bad;
                        cnt     <= '0;
                        if (req_bad)
                            state <= DONE;
                        else if (bus.req_write)
                            state <= WREQ;
                        else
                            state <= RADDR;
                    end
                end
                RADDR: begin
                    if (bus.dr_addr_ready) begin
                        state <= RDATA;
                        cnt   <= '0;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                RDATA: begin
                    if (bus.dr_data_valid) begin
                        rdata_q <= ld_ext;
                        state   <= DONE;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                WREQ: begin
                    if (bus.dw_ready) begin
                        state <= WRESP;
                        cnt   <= '0;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                WRESP: begin
                    if (bus.dw_resp_valid) begin
                        err_q <= ~bus.dw_resp;
                        state <= DONE;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.resp_valid    = (state == DONE);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_error    = err_q;
    assign bus.dr_addr_valid = (state == RADDR);
    assign bus.dr_addr       = aligned;
    assign bus.dr_data_ready = (state == RDATA);
    assign bus.dw_valid      = (state == WREQ);
    assign bus.dw_addr       = aligned;
    assign bus.dw_data       = wdata_q << {off, 3'b000};
    assign bus.dw_strobe     = (state == WREQ) ? (smask << off) : '0;
    assign bus.dw_resp_ready = (state == WRESP);
endmodule

// File: tb/tb_copperv_lsu.sv
// Bench for copperv_lsu: 32-bit (timeout 8) and 64-bit (timeout 255)
// instances driven from one shared stimulus path selected by sel.
module tb_copperv_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel;
    logic        req_valid, req_write;
    logic [4:0]  req_funct;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, dr_data;
    logic        dr_addr_ready, dr_data_valid;
    logic        dw_ready, dw_resp_valid, dw_resp;

    logic        o_req_ready, o_resp_valid, o_resp_error;
    logic [63:0] o_resp_rdata, o_dw_data;
    logic        o_dr_addr_valid, o_dr_data_ready;
    logic        o_dw_valid, o_dw_resp_ready;
    logic [31:0] o_dr_addr, o_dw_addr;
    logic [7:0]  o_dw_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    copperv_lsu_if #(.DATA_WIDTH(32)) b32 ();
    copperv_lsu_if #(.DATA_WIDTH(64)) b64 ();

    copperv_lsu #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .FUNCT_WIDTH(5), .TIMEOUT_CYCLES(8)
    ) u32 (.clk(clk), .rst(rst), .bus(b32));

    copperv_lsu #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32),
        .FUNCT_WIDTH(5), .TIMEOUT_CYCLES(255)
    ) u64 (.clk(clk), .rst(rst), .bus(b64));

    assign b32.req_valid     = req_valid & ~sel;
    assign b64.req_valid     = req_valid & sel;
    assign b32.req_write     = req_write;
    assign b64.req_write     = req_write;
    assign b32.req_funct     = req_funct;
    assign b64.req_funct     = req_funct;
    assign b32.req_addr      = req_addr;
    assign b64.req_addr      = req_addr;
    assign b32.req_wdata     = req_wdata[31:0];
    assign b64.req_wdata     = req_wdata;
    assign b32.dr_addr_ready = dr_addr_ready & ~sel;
    assign b64.dr_addr_ready = dr_addr_ready & sel;
    assign b32.dr_data_valid = dr_data_valid & ~sel;
    assign b64.dr_data_valid = dr_data_valid & sel;
    assign b32.dr_data       = dr_data[31:0];
    assign b64.dr_data       = dr_data;
    assign b32.dw_ready      = dw_ready & ~sel;
    assign b64.dw_ready      = dw_ready & sel;
    assign b32.dw_resp_valid = dw_resp_valid & ~sel;
    assign b64.dw_resp_valid = dw_resp_valid & sel;
    assign b32.dw_resp       = dw_resp;
    assign b64.dw_resp       = dw_resp;

    assign o_req_ready     = sel ? b64.req_ready : b32.req_ready;
    assign o_resp_valid    = sel ? b64.resp_valid : b32.resp_valid;
    assign o_resp_error    = sel ? b64.resp_error : b32.resp_error;
    assign o_resp_rdata    = sel ? b64.resp_rdata : {32'h0, b32.resp_rdata};
    assign o_dr_addr_valid = sel ? b64.dr_addr_valid : b32.dr_addr_valid;
    assign o_dr_addr       = sel ? b64.dr_addr : b32.dr_addr;
    assign o_dr_data_ready = sel ? b64.dr_data_ready : b32.dr_data_ready;
    assign o_dw_valid      = sel ? b64.dw_valid : b32.dw_valid;
    assign o_dw_addr       = sel ? b64.dw_addr : b32.dw_addr;
    assign o_dw_data       = sel ? b64.dw_data : {32'h0, b32.dw_data};
    assign o_dw_strobe     = sel ? b64.dw_strobe : {4'h0, b32.dw_strobe};
    assign o_dw_resp_ready = sel ? b64.dw_resp_ready : b32.dw_resp_ready;

    typedef struct {
        int          lat;
        logic [63:0] rdata;
        logic        err;
        int          nra;
        int          nwr;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [63:0] wd;
        logic [7:0]  ws;
        logic        stable;
        logic        hung;
        logic        ab_rr;
        logic        ab_drr;
        int          ab_nresp;
    } obs_t;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // never: phase (1 raddr, 2 rdata, 3 wreq, 4 wresp) that never handshakes
    task automatic run_req(
        input logic wr, input logic [4:0] f, input logic [31:0] a,
        input logic [63:0] wd, input logic [63:0] rd, input logic ok,
        input int wt, input int never, input bit abort,
        output obs_t o
    );
        int  w;
        bit  done;
        o = '{default: 0};
        o.stable = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_funct = f;
        req_addr = a; req_wdata = wd; dr_data = rd; dw_resp = ok;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o.lat = 1;
        w = 0;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            int ph;
            bit rdy;
            o.lat++;
            dr_addr_ready = 0; dr_data_valid = 0;
            dw_ready = 0; dw_resp_valid = 0;
            if (o_resp_valid) begin
                o.rdata = o_resp_rdata;
                o.err = o_resp_error;
                done = 1;
            end else if (abort && o_dw_resp_ready) begin
                rst = 1'b1;
                @(posedge clk); #1;
                o.ab_rr = o_req_ready;
                o.ab_drr = o_dw_resp_ready;
                rst = 1'b0;
                repeat (12) begin
                    @(posedge clk); #1;
                    if (o_resp_valid) o.ab_nresp++;
                end
                done = 1;
            end else begin
                ph = 0;
                if (o_dr_addr_valid) ph = 1;
                else if (o_dr_data_ready) ph = 2;
                else if (o_dw_valid) ph = 3;
                else if (o_dw_resp_ready) ph = 4;
                rdy = (ph != 0) && (ph != never) && (w >= wt);
                w = rdy ? 0 : w + 1;
                case (ph)
                    1: begin
                        o.nra++;
                        o.ra = o_dr_addr;
                        dr_addr_ready = rdy;
                    end
                    2: dr_data_valid = rdy;
                    3: begin
                        if (o.nwr == 0) begin
                            o.wa = o_dw_addr;
                            o.wd = o_dw_data;
                            o.ws = o_dw_strobe;
                        end else if (o_dw_addr !== o.wa || o_dw_data !== o.wd
                                     || o_dw_strobe !== o.ws) begin
                            o.stable = 1'b0;
                        end
                        o.nwr++;
                        dw_ready = rdy;
                    end
                    4: dw_resp_valid = rdy;
                    default: ;
                endcase
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) o.hung = 1'b1;
        dr_addr_ready = 0; dr_data_valid = 0;
        dw_ready = 0; dw_resp_valid = 0;
    endtask

    function automatic int size_of(input logic [4:0] f);
        case (f)
            5'd9, 5'd12:  return 1;
            5'd10, 5'd13: return 2;
            5'd11:        return 4;
            default:      return 0;
        endcase
    endfunction

    function automatic bit is_bad(input logic [4:0] f, input logic [31:0] a);
        int sz = size_of(f);
        if (sz == 0) return 1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [63:0] dmask(input int nb);
        return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] exp_load(
        input logic [4:0] f, input logic [31:0] a,
        input logic [63:0] rd, input int nb
    );
        int          sz = size_of(f);
        int          off = a % nb;
        logic [63:0] m = (64'd1 << (8 * sz)) - 64'd1;
        logic [63:0] v = ((rd & dmask(nb)) >> (8 * off)) & m;
        if ((f == 5'd9 || f == 5'd10 || f == 5'd11) && v[8*sz-1])
            v = v | ~m;
        return v & dmask(nb);
    endfunction

    initial begin
        obs_t o;
        int   nb, sz, wt;
        logic [4:0]  f;
        logic [31:0] a;
        logic [63:0] wd, rd;
        logic        wr, ok;
        bit          bad;

        rst = 1; sel = 0; req_valid = 0; req_write = 0; req_funct = 0;
        req_addr = 0; req_wdata = 0; dr_data = 0; dr_addr_ready = 0;
        dr_data_valid = 0; dw_ready = 0; dw_resp_valid = 0; dw_resp = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_req_ready", o_req_ready, 1);
            chk("rst_resp_valid", o_resp_valid, 0);
            chk("rst_dr_addr_valid", o_dr_addr_valid, 0);
            chk("rst_dw_valid", o_dw_valid, 0);
            chk("rst_dw_resp_ready", o_dw_resp_ready, 0);
            chk("rst_dw_strobe", o_dw_strobe, 0);
            chk("rst_resp_rdata", o_resp_rdata, 0);
            chk("rst_resp_error", o_resp_error, 0);
        end
        rst = 0;

        sel = 0;
        run_req(0, 5'd9, 32'h1003, 0, 64'h80FF_FFFF, 1, 0, 0, 0, o);
        chk("lb_rdata", o.rdata, 64'hFFFF_FF80);
        chk("lb_err", o.err, 0);
        chk("lb_lat", o.lat, 4);
        chk("lb_addr", o.ra, 32'h1000);

        sel = 1;
        run_req(1, 5'd10, 32'h106, 64'hABCD, 0, 1, 0, 0, 0, o);
        chk("sh64_addr", o.wa, 32'h100);
        chk("sh64_strobe", o.ws, 8'hC0);
        chk("sh64_data", o.wd, 64'hABCD_0000_0000_0000);
        chk("sh64_err", o.err, 0);
        chk("sh64_lat", o.lat, 4);

        sel = 0;
        run_req(0, 5'd11, 32'h2002, 0, 64'h1234, 1, 0, 0, 0, o);
        chk("lw_mis_lat", o.lat, 2);
        chk("lw_mis_err", o.err, 1);
        chk("lw_mis_nobus", o.nra + o.nwr, 0);

        run_req(1, 5'd11, 32'h40, 64'h1122_3344, 0, 0, 0, 0, 0, o);
        chk("sw_fail_err", o.err, 1);
        chk("sw_fail_rdata", o.rdata, 0);

        sel = 1;
        run_req(1, 5'd11, 32'h44, 64'h5566_7788, 0, 1, 10, 0, 0, o);
        chk("sw_stall_stable", o.stable, 1);
        chk("sw_stall_len", o.nwr, 11);
        chk("sw_stall_data", o.wd, 64'h5566_7788_0000_0000);
        chk("sw_stall_err", o.err, 0);

        sel = 0;
        run_req(0, 5'd11, 32'h10, 0, 64'hDEAD_BEEF, 1, 0, 2, 0, o);
        chk("tmo_err", o.err, 1);
        chk("tmo_rdata", o.rdata, 0);
        chk("tmo_lat", o.lat, 3 + 8);
        chk("tmo_hung", o.hung, 0);
        run_req(0, 5'd12, 32'h0, 0, 64'hF0, 1, 0, 0, 0, o);
        chk("lbu_after_tmo", o.rdata, 64'hF0);
        chk("lbu_after_tmo_err", o.err, 0);

        sel = 1;
        run_req(1, 5'd11, 32'h8, 64'h1, 0, 1, 0, 4, 1, o);
        chk("abort_req_ready", o.ab_rr, 1);
        chk("abort_dw_resp_ready", o.ab_drr, 0);
        chk("abort_no_resp", o.ab_nresp, 0);

        for (int i = 0; i < 60; i++) begin
            int r;
            sel = $urandom_range(0, 1) != 0;
            nb = sel ? 8 : 4;
            r = $urandom_range(0, 9);
            f = (r < 8) ? 5'(9 + r % 5) : ((r == 8) ? 5'd3 : 5'd20);
            sz = size_of(f);
            a = $urandom;
            if (sz > 1 && $urandom_range(0, 3) != 0)
                a = a & ~32'(sz - 1);
            wr = $urandom_range(0, 1) != 0;
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            ok = $urandom_range(0, 4) != 0;
            wt = $urandom_range(0, 3);
            bad = is_bad(f, a);
            run_req(wr, f, a, wd, rd, ok, wt, 0, 0, o);
            chk("rnd_hung", o.hung, 0);
            chk("rnd_lat", o.lat, bad ? 2 : 4 + 2 * wt);
            if (bad) begin
                chk("rnd_bad_err", o.err, 1);
                chk("rnd_bad_nobus", o.nra + o.nwr, 0);
                chk("rnd_bad_rdata", o.rdata, 0);
            end else if (wr) begin
                chk("rnd_st_err", o.err, !ok);
                chk("rnd_st_rdata", o.rdata, 0);
                chk("rnd_st_addr", o.wa, a - (a % nb));
                chk("rnd_st_strobe", o.ws,
                    8'(((1 << sz) - 1) << (a % nb)));
                chk("rnd_st_data", o.wd,
                    ((wd & dmask(nb)) << (8 * (a % nb))) & dmask(nb));
            end else begin
                chk("rnd_ld_err", o.err, 0);
                chk("rnd_ld_addr", o.ra, a - (a % nb));
                chk("rnd_ld_rdata", o.rdata, exp_load(f, a, rd, nb));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/copperv_lsu.md
Name: copperv_lsu

Overview:
Parametrised load/store unit between the control_unit MEM state and the copperv data bus. Accepts one memory request at a time for byte, halfword and word (signed and unsigned) accesses. Generates byte-lane strobes and lane-aligned write data, and sign/zero-extends read data. Flags misaligned accesses, fail write responses and bus timeouts as errors. Supports DATA_WIDTH of 32 or 64.

Parameters:
DATA_WIDTH, 32, bus and register data width; legal values 32 or 64.
ADDR_WIDTH, 32, byte address width.
FUNCT_WIDTH, 5, width of the funct code.
TIMEOUT_CYCLES, 255, maximum cycles to wait for any bus handshake; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  LSU idle and able to accept a request
req_write  in  1  1 = store, 0 = load
req_funct  in  FUNCT_WIDTH  funct_mem_byte(9), hword(10), word(11), byteu(12), hwordu(13)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_error  out  1  qualified by resp_valid
dr_addr_valid / dr_addr_ready  out / in  1  read address handshake
dr_addr  out  ADDR_WIDTH  lane-aligned read address
dr_data_valid / dr_data_ready  in / out  1  read data handshake
dr_data  in  DATA_WIDTH  read data
dw_valid / dw_ready  out / in  1  write address+data handshake
dw_addr  out  ADDR_WIDTH  lane-aligned write address
dw_data  out  DATA_WIDTH  write data shifted to the addressed lane
dw_strobe  out  DATA_WIDTH/8  byte enables
dw_resp_valid / dw_resp_ready  in / out  1  write response handshake
dw_resp  in  1  0 = fail, 1 = ok

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- Reset: state = IDLE. All valid/ready outputs are 0 except req_ready = 1. resp_rdata = 0, resp_error = 0, dw_strobe = 0.
- IDLE: req_ready = 1. On req_valid, latch funct, addr and wdata.
  - Misaligned request (hword with addr[0] != 0; word with addr[1:0] != 0) or unsupported funct: go to DONE with error = 1. No bus traffic is issued.
  - Otherwise go to RADDR for a load or WREQ for a store.
- Aligned bus address: addr with the low log2(DATA_WIDTH/8) bits cleared. Lane offset: those low bits.
- RADDR: assert dr_addr_valid. On dr_addr_ready, go to RDATA.
- RDATA: assert dr_data_ready. On dr_data_valid, capture dr_data shifted right by 8*offset. Sign-extend byte/hword; zero-extend byteu/hwordu. For DATA_WIDTH = 64, word is sign-extended. Then go to DONE.
- WREQ: dw_valid held until dw_ready. dw_data = wdata << (8*offset). Strobe is 1, 2 or 4 contiguous bits starting at bit offset. Then go to WRESP.
- WRESP: assert dw_resp_ready. On dw_resp_valid, error = (dw_resp == 0). Then go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then go to IDLE. req_ready = 0 in DONE, so back-to-back requests see one idle cycle between them.
- Latency with zero-wait bus: load 4 cycles and store 4 cycles from acceptance to resp_valid; misaligned 2 cycles.
- Valid outputs never drop before their handshake completes. Addr, data and strobe are stable while valid is high.
- Timeout: a counter resets on entry to each of RADDR, RDATA, WREQ and WRESP. When it reaches TIMEOUT_CYCLES, drop the pending valid/ready, go to DONE with error = 1 and rdata = 0.
- Simultaneous handshake in the same cycle as valid rises: completes in that cycle.
- rst asserted mid-transaction: return to IDLE on the next edge and drop all bus valids. No response is issued for the aborted request.

Test Plan:
- DATA_WIDTH = 32, lb at 0x1003, dr_data = 0x80FFFFFF, zero-wait bus -> resp_rdata = 0xFFFFFF80, error = 0, resp_valid 4 cycles after acceptance.
- DATA_WIDTH = 64, sh at 0x106 with wdata = 0xABCD -> dw_addr = 0x100, dw_strobe = 0xC0, dw_data = 0xABCD000000000000. Then dw_resp = 1 -> error = 0.
- lw at 0x2002 -> resp_valid 2 cycles after acceptance with error = 1; dr_addr_valid never asserted.
- sw with dw_resp = 0 -> resp_error = 1. A store with dw_ready held low for 10 cycles -> dw_valid stays high and dw_data stays stable throughout.
- TIMEOUT_CYCLES = 8, dr_data_valid never asserted -> error response 8 cycles after entering RDATA; a following lbu at 0x0 with dr_data = 0x000000F0 returns 0x000000F0.
- rst pulsed while in WRESP -> req_ready = 1 and dw_resp_ready = 0 on the next cycle; no resp_valid.
